// File: rtl/cache_pkg.sv
// Shared types and sizes for the cache line refill engine.
// Lines are LINE_WORDS 32-bit words; slot/offset arithmetic wraps modulo 4.
package cache_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int WORD_W      = 32;
    localparam int LINE_ADDR_W = 28;
    localparam int CNT_W       = 3;
    localparam int SLOT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } refill_state_e;

    // Wrapping word offset: critical word plus beat count, modulo 4.
    function automatic logic [SLOT_W-1:0] wrap_slot(
        input logic [SLOT_W-1:0] crit,
        input logic [SLOT_W-1:0] cnt
    );
        return crit + cnt;
    endfunction

endpackage

// File: rtl/cache_refill_buf.sv
// Line buffer for the refill engine: one word slot written per enabled cycle.
// Unwritten slots keep their previous contents; reset clears the whole line.
module cache_refill_buf
    import cache_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic                          i_hclk,
    input  logic                          i_hreset,
    input  logic                          wr_en,
    input  logic [SLOT_W-1:0]             wr_slot,
    input  logic [WORD_W-1:0]             wr_data,
    output logic [NUM_SLOTS*WORD_W-1:0]   line
);

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            line <= '0;
        end else if (wr_en) begin
            line[int'(wr_slot)*WORD_W +: WORD_W] <= wr_data;
        end
    end

endmodule

// File: rtl/cache_line_refill.sv
// Critical-word-first cache line refill engine: issues four wrapping word reads
// downstream, forwards the critical word early and signals when the line is full.
module cache_line_refill #(
    parameter int LINE_WORDS = 4
) (
    input  logic                                           i_hclk,
    input  logic                                           i_hreset,
    input  logic                                           i_req,
    input  logic [cache_pkg::LINE_ADDR_W+cache_pkg::SLOT_W-1:0] i_req_addr,
    output logic                                           o_busy,
    output logic                                           o_crit_valid,
    output logic [cache_pkg::WORD_W-1:0]                   o_crit_data,
    output logic                                           o_done,
    output logic [LINE_WORDS*cache_pkg::WORD_W-1:0]        o_line,
    output logic [cache_pkg::LINE_ADDR_W-1:0]              o_line_addr,
    output logic                                           o_sel,
    output logic [cache_pkg::LINE_ADDR_W+cache_pkg::SLOT_W-1:0] o_addr,
    input  logic [cache_pkg::WORD_W-1:0]                   i_rdata,
    input  logic                                           i_ready
);

    import cache_pkg::*;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(LINE_WORDS);

    refill_state_e       state_q, state_d;
    logic [CNT_W-1:0]    acnt_q, dcnt_q;
    logic [SLOT_W-1:0]   crit_q;
    logic                pending_q;
    logic                addr_beat, data_beat;

    assign addr_beat = o_sel && i_ready;
    assign data_beat = pending_q && i_ready;

    always_comb begin
        state_d = state_q;
        o_sel   = (state_q == ST_FILL) && (acnt_q < ALL_BEATS);
        o_busy  = (state_q != ST_IDLE);
        o_done  = (state_q == ST_DONE);
        o_addr  = {o_line_addr, wrap_slot(crit_q, acnt_q[SLOT_W-1:0])};
        case (state_q)
            ST_IDLE:  if (i_req) state_d = ST_FILL;
            ST_FILL:  if (addr_beat && acnt_q == LAST_BEAT) state_d = ST_DRAIN;
            ST_DRAIN: if (data_beat && dcnt_q == LAST_BEAT) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // An address beat always leaves a data beat pending; a lone data beat retires it.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q      <= ST_IDLE;
            acnt_q       <= '0;
            dcnt_q       <= '0;
            crit_q       <= '0;
            pending_q    <= 1'b0;
            o_line_addr  <= '0;
            o_crit_valid <= 1'b0;
            o_crit_data  <= '0;
        end else begin
            state_q      <= state_d;
            o_crit_valid <= data_beat && (dcnt_q == '0);
            if (data_beat && dcnt_q == '0) begin
                o_crit_data <= i_rdata;
            end
            if (state_q == ST_IDLE && i_req) begin
                o_line_addr <= i_req_addr[LINE_ADDR_W+SLOT_W-1:SLOT_W];
                crit_q      <= i_req_addr[SLOT_W-1:0];
                acnt_q      <= '0;
                dcnt_q      <= '0;
                pending_q   <= 1'b0;
            end else begin
                if (addr_beat) begin
                    acnt_q <= acnt_q + CNT_W'(1);
                end
                if (data_beat) begin
                    dcnt_q <= dcnt_q + CNT_W'(1);
                end
                if (addr_beat) begin
                    pending_q <= 1'b1;
                end else if (data_beat) begin
                    pending_q <= 1'b0;
                end
            end
        end
    end

    cache_refill_buf #(
        .NUM_SLOTS (LINE_WORDS)
    ) u_buf (
        .i_hclk   (i_hclk),
        .i_hreset (i_hreset),
        .wr_en    (data_beat),
        .wr_slot  (wrap_slot(crit_q, dcnt_q[SLOT_W-1:0])),
        .wr_data  (i_rdata),
        .line     (o_line)
    );

endmodule
